// File: rtl/alu_seq_if.sv
// Handshake bundle between the decode stage (master) and alu_op_sequencer (slave).
// Request side: in_valid/in_ready plus opcode and operands.
// Result side: out_valid/out_ready plus rdval, busy and err.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] rsval;
  logic [WIDTH-1:0] rtval;
  logic [2:0]       shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rdval;
  logic             busy;
  logic             err;

  modport master (
    output in_valid, opcode, rsval, rtval, shamt, out_ready,
    input  in_ready, out_valid, rdval, busy, err
  );

  modport slave (
    input  in_valid, opcode, rsval, rtval, shamt, out_ready,
    output in_ready, out_valid, rdval, busy, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-end controller for the ALU datapath.
// Single-cycle ops finish in one cycle; MUL is an iterative shift-add and
// DIV an iterative restoring division, each taking WIDTH step cycles.
// Owns the HI/LO registers read back by MFLO/MFHI.
// Optional feature macro: ALU_SEQ_ERR_EN (err flags DIV-by-zero and
// undefined opcodes; without it err is always 0).
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef ALU_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_rdval;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_err;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;      // multiplicand (MUL) or divisor (DIV)
  logic [2*WIDTH-1:0] r_prod;   // MUL: {partial, multiplier}; DIV: {remainder, quotient}

  logic               w_accept;
  logic [WIDTH-1:0]   w_single;
  logic               w_err_flag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_accept      = bus.in_valid && (r_state == S_IDLE) && !r_out_valid;
  assign bus.in_ready  = (r_state == S_IDLE) && !r_out_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.rdval     = r_rdval;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

  // Result of every op that completes at the accept edge (DIV by zero included).
  always_comb begin
    w_single   = '0;
    w_err_flag = 1'b0;
    case (bus.opcode)
      4'd0:    w_single = bus.rsval + bus.rtval;
      4'd1:    w_single = bus.rsval << bus.shamt;
      4'd2:    w_single = bus.rsval >> bus.shamt;
      4'd3:    w_single = '0;
      4'd4:    begin w_single = '1; w_err_flag = 1'b1; end
      4'd6:    w_single = bus.rsval | bus.rtval;
      4'd7:    w_single = bus.rsval & bus.rtval;
      4'd11:   w_single = r_lo;
      4'd12:   w_single = r_hi;
      default: begin w_single = '0; w_err_flag = 1'b1; end
    endcase
  end

  // One shift-add step: add multiplicand into upper half when the current multiplier bit is set, then shift right.
  always_comb begin
    w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};
  end

  // One restoring step: shift next dividend bit into remainder, trial subtract, keep or restore.
  always_comb begin
    w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, r_a};
    if (w_div_trial[WIDTH])
      w_div_next = {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
    else
      w_div_next = {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
  end

  // Control FSM with registered outputs and HI/LO ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rdval     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.opcode == 4'd3) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(WIDTH-1);
            end else if (bus.opcode == 4'd4 && bus.rtval != '0) begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(WIDTH-1);
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_rdval     <= w_single;
              r_err       <= w_err_flag & ERR_EN;
              if (bus.opcode == 4'd4) begin
                r_lo <= '1;
                r_hi <= bus.rsval;
              end
            end
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_err       <= 1'b0;
            r_rdval     <= w_mul_next[WIDTH-1:0];
            r_lo        <= w_mul_next[WIDTH-1:0];
            r_hi        <= w_mul_next[2*WIDTH-1:WIDTH];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_err       <= 1'b0;
            r_rdval     <= w_div_next[WIDTH-1:0];
            r_lo        <= w_div_next[WIDTH-1:0];
            r_hi        <= w_div_next[2*WIDTH-1:WIDTH];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Iteration datapath: operands loaded on accept, advanced one step per MUL/DIV cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (bus.opcode == 4'd3) begin
        r_a    <= bus.rsval;
        r_prod <= {{WIDTH{1'b0}}, bus.rtval};
      end else begin
        r_a    <= bus.rtval;
        r_prod <= {{WIDTH{1'b0}}, bus.rsval};
      end
    end else if (r_state == S_MUL) begin
      r_prod <= w_mul_next;
    end else if (r_state == S_DIV) begin
      r_prod <= w_div_next;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed literal cases plus randomized
// traffic, checked against a transaction-level model of the sequencer.
module tb_alu_op_sequencer;
`ifdef ALU_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   cmp_en = 1'b0;
  bit   rand_rdy = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_op_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_hi, m_lo, m_rd, p_rd, p_hi, p_lo;
  logic        m_ov, m_err, p_err;
  int          m_wait;

  function automatic void model_eval(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] sh, input logic [15:0] hi_in, input logic [15:0] lo_in,
                                     output logic [15:0] rd, output logic [15:0] hi, output logic [15:0] lo,
                                     output logic er, output int lat);
    logic [31:0] p;
    rd = 16'h0; hi = hi_in; lo = lo_in; er = 1'b0; lat = 1;
    case (op)
      4'd0:  rd = 16'(a + b);
      4'd1:  rd = 16'(a << sh);
      4'd2:  rd = a >> sh;
      4'd3:  begin p = {16'h0, a} * {16'h0, b}; lo = p[15:0]; hi = p[31:16]; rd = lo; lat = W + 1; end
      4'd4:  begin
               if (b == 16'h0) begin rd = 16'hFFFF; lo = 16'hFFFF; hi = a; er = ERR_EN; end
               else begin lo = a / b; hi = a % b; rd = lo; lat = W + 1; end
             end
      4'd6:  rd = a | b;
      4'd7:  rd = a & b;
      4'd11: rd = lo_in;
      4'd12: rd = hi_in;
      default: begin rd = 16'h0; er = ERR_EN; end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_rd = 0; m_ov = 0; m_err = 0; m_wait = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_ov = 1; m_rd = p_rd; m_hi = p_hi; m_lo = p_lo; m_err = p_err; end
    end else if (m_ov) begin
      if (bus.out_ready) begin m_ov = 0; m_err = 0; end
    end else if (bus.in_valid) begin
      int lat;
      model_eval(bus.opcode, bus.rsval, bus.rtval, bus.shamt, m_hi, m_lo, p_rd, p_hi, p_lo, p_err, lat);
      if (lat == 1) begin m_ov = 1; m_rd = p_rd; m_hi = p_hi; m_lo = p_lo; m_err = p_err; end
      else m_wait = lat - 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc_out_valid", {31'h0, bus.out_valid}, {31'h0, m_ov});
      chk("cyc_busy", {31'h0, bus.busy}, {31'h0, (m_wait > 0)});
      chk("cyc_in_ready", {31'h0, bus.in_ready}, {31'h0, (!m_ov && m_wait == 0)});
      if (m_ov) begin
        chk("cyc_rdval", {16'h0, bus.rdval}, {16'h0, m_rd});
        chk("cyc_err", {31'h0, bus.err}, {31'h0, m_err});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] sh);
    bit acc = 0;
    int n = 0;
    bus.in_valid = 1'b1; bus.opcode = op; bus.rsval = a; bus.rtval = b; bus.shamt = sh;
    while (!acc && n < 100) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] sh,
                        input int hold, output logic [15:0] rd, output logic er, output int lat, output int bc);
    bit got = 0;
    rd = 0; er = 0; lat = 0; bc = 0;
    issue(op, a, b, sh);
    while (!got && lat < 40) begin
      @(negedge clk); lat++;
      if (bus.busy) bc++;
      if (bus.out_valid) begin got = 1; rd = bus.rdval; er = bus.err; end
    end
    if (!got) chk("result_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_rdval", {16'h0, bus.rdval}, {16'h0, rd});
      chk("stall_in_ready", {31'h0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat, bc;
    logic [3:0]  ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd11, 4'd12, 4'd5, 4'd9, 4'd15};

    bus.in_valid = 0; bus.opcode = 0; bus.rsval = 0; bus.rtval = 0; bus.shamt = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_err", {31'h0, bus.err}, 32'd0);
    chk("rst_rdval", {16'h0, bus.rdval}, 32'd0);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    cmp_en = 1'b1;

    run_op(4'd0, 16'hFFFF, 16'h0002, 3'd0, 0, rd, er, lat, bc);
    chk("add_rd", {16'h0, rd}, 32'h0001);
    chk("add_lat", lat, 1);
    run_op(4'd1, 16'h8001, 16'h0000, 3'd3, 0, rd, er, lat, bc);
    chk("sll_rd", {16'h0, rd}, 32'h0008);
    run_op(4'd3, 16'h1234, 16'h0100, 3'd0, 5, rd, er, lat, bc);
    chk("mul_rd", {16'h0, rd}, 32'h3400);
    chk("mul_lat", lat, 17);
    chk("mul_busy_cycles", bc, 16);
    run_op(4'd12, 16'h0, 16'h0, 3'd0, 0, rd, er, lat, bc);
    chk("mfhi_after_mul", {16'h0, rd}, 32'h0012);
    run_op(4'd11, 16'h0, 16'h0, 3'd0, 0, rd, er, lat, bc);
    chk("mflo_after_mul", {16'h0, rd}, 32'h3400);
    run_op(4'd4, 16'd100, 16'd7, 3'd0, 0, rd, er, lat, bc);
    chk("div_rd", {16'h0, rd}, 32'd14);
    chk("div_lat", lat, 17);
    run_op(4'd12, 16'h0, 16'h0, 3'd0, 0, rd, er, lat, bc);
    chk("mfhi_after_div", {16'h0, rd}, 32'd2);
    run_op(4'd4, 16'd5, 16'd0, 3'd0, 0, rd, er, lat, bc);
    chk("div0_rd", {16'h0, rd}, 32'hFFFF);
    chk("div0_lat", lat, 1);
    chk("div0_err", {31'h0, er}, {31'h0, ERR_EN});
    run_op(4'd12, 16'h0, 16'h0, 3'd0, 0, rd, er, lat, bc);
    chk("mfhi_after_div0", {16'h0, rd}, 32'd5);
    run_op(4'd9, 16'h1111, 16'h2222, 3'd0, 0, rd, er, lat, bc);
    chk("undef_rd", {16'h0, rd}, 32'h0);
    chk("undef_err", {31'h0, er}, {31'h0, ERR_EN});

    // Reset in the middle of a multiply.
    issue(4'd3, 16'hABCD, 16'h1234, 3'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rstmul_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rstmul_busy", {31'h0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    run_op(4'd11, 16'h0, 16'h0, 3'd0, 0, rd, er, lat, bc);
    chk("rstmul_lo", {16'h0, rd}, 32'h0);
    run_op(4'd12, 16'h0, 16'h0, 3'd0, 0, rd, er, lat, bc);
    chk("rstmul_hi", {16'h0, rd}, 32'h0);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      op = ops[$urandom_range(0, 11)];
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      issue(op, a, b, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    #2 bus.out_ready = 1'b1;
    repeat (25) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
